seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider. It is the sequential, width-generic successor to the team's 4-bit combinational divider.
- Computes one quotient bit per clock, using a start/busy/done handshake.
- Supports unsigned and signed (truncating) division and explicit divide-by-zero handling.
- Intended as the shared divide unit behind the CPU ALU / microcode sequencer, where a long combinational chain is unacceptable.

---
 rtl/seq_divider.sv | 145 ++++++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake,
// unsigned or truncating signed division, explicit divide-by-zero result.
module seq_divider #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic             accept_c, step_c, load_c;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, zero_q;

  logic             sgn_c, dvd_neg_c, dvs_neg_c;
  logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
  logic [WIDTH:0]   shifted_c;
  logic             no_borrow_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] q_fix_c, r_fix_c;

  // Operand magnitudes and recorded signs at accept time
  always_comb begin
    sgn_c     = SIGNED_EN && signed_mode;
    dvd_neg_c = sgn_c && dividend[WIDTH-1];
    dvs_neg_c = sgn_c && divisor[WIDTH-1];
    dvd_mag_c = dvd_neg_c ? WIDTH'(-dividend) : dividend;
    dvs_mag_c = dvs_neg_c ? WIDTH'(-divisor) : divisor;
  end

  // One restoring step; the partial remainder always stays below the divisor,
  // so only the low WIDTH bits of the difference need to be kept.
  always_comb begin
    shifted_c   = {acc, qreg[WIDTH-1]};
    no_borrow_c = (shifted_c >= {1'b0, dvs_mag});
    diff_c      = shifted_c[WIDTH-1:0] - dvs_mag;
    q_fix_c     = neg_q ? WIDTH'(-qreg) : qreg;
    r_fix_c     = neg_r ? WIDTH'(-acc) : acc;
  end

  // Next-state and control decode
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (zero_q || (cnt == CW'(WIDTH))) begin
          load_c  = 1'b1;
          state_d = FINISH;
        end else begin
          step_c = 1'b1;
        end
      end
      FINISH: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      qreg        <= '0;
      dvs_mag     <= '0;
      dvd_raw     <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == FINISH);

      if (accept_c) begin
        acc     <= '0;
        qreg    <= dvd_mag_c;
        dvs_mag <= dvs_mag_c;
        dvd_raw <= dividend;
        neg_q   <= dvd_neg_c ^ dvs_neg_c;
        neg_r   <= dvd_neg_c;
        zero_q  <= (divisor == '0);
        cnt     <= '0;
      end

      if (step_c) begin
        acc  <= no_borrow_c ? diff_c : shifted_c[WIDTH-1:0];
        qreg <= {qreg[WIDTH-2:0], no_borrow_c};
        cnt  <= cnt + CW'(1);
      end

      if (load_c) begin
        if (zero_q) begin
          quotient    <= '1;
          remainder   <= dvd_raw;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= q_fix_c;
          remainder   <= r_fix_c;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and handshake bench for seq_divider at WIDTH=16, plus a short
// randomised run against a behavioural reference.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one operation; returns the number of edges after the accept edge until done.
  task automatic do_op(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_at_accept", 32'(busy), 32'd1);
    chk("done_at_accept", 32'(done), 32'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic model(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic z);
    logic signed [15:0] sa, sb;
    sa = a; sb = b;
    z  = 1'b0;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else if (sm) begin
      if (a == 16'h8000 && b == 16'hFFFF) begin
        q = 16'h8000; r = 16'd0;
      end else begin
        q = 16'(sa / sb);
        r = 16'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    int          lat;
    int          n;
    int          done_seen;
    logic [15:0] eq, er;
    logic        ez, sm;
    logic [15:0] a, b;

    vecs[0]  = '{1'b0, 16'd1000,  16'd7,     16'd142,   16'd6,     1'b0};
    vecs[1]  = '{1'b1, 16'hFFF9,  16'h0002,  16'hFFFD,  16'hFFFF,  1'b0};
    vecs[2]  = '{1'b0, 16'hFFF9,  16'h0002,  16'h7FFC,  16'h0001,  1'b0};
    vecs[3]  = '{1'b0, 16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1};
    vecs[4]  = '{1'b0, 16'd9,     16'd3,     16'd3,     16'd0,     1'b0};
    vecs[5]  = '{1'b1, 16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b0};
    vecs[6]  = '{1'b0, 16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0};
    vecs[7]  = '{1'b1, 16'h0007,  16'hFFFE,  16'hFFFD,  16'h0001,  1'b0};
    vecs[8]  = '{1'b1, 16'hFFF9,  16'hFFFE,  16'h0003,  16'hFFFF,  1'b0};
    vecs[9]  = '{1'b1, 16'hFFF9,  16'h0000,  16'hFFFF,  16'hFFF9,  1'b1};
    vecs[10] = '{1'b0, 16'd5,     16'd9,     16'd0,     16'd5,     1'b0};
    vecs[11] = '{1'b1, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].sm, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].b == 16'd0) ? 32'd1 : 32'd17);
      chk($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].z));
      chk($sformatf("vec%0d_busy_in_done", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Start pulse at k+3 with different operands must be ignored
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 16'd1000; divisor = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5; signed_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignored_start_latency", 32'(n), 32'd17);
    chk("ignored_start_quotient", 32'(quotient), 32'd142);
    chk("ignored_start_remainder", 32'(remainder), 32'd6);

    // Back-to-back: new start issued in the done cycle
    do_op(1'b0, 16'd9, 16'd3, lat);
    chk("b2b_latency", 32'(lat), 32'd17);
    chk("b2b_quotient", 32'(quotient), 32'd3);
    chk("b2b_remainder", 32'(remainder), 32'd0);

    // Leave non-zero results (and the flag) so reset clearing is visible
    do_op(1'b0, 16'h1234, 16'h0000, lat);
    chk("pre_reset_dbz", 32'(div_by_zero), 32'd1);

    // Reset at k+5 aborts without a done pulse
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 16'd1000; divisor = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    // Randomised operands against the reference model
    for (int i = 0; i < 300; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      model(sm, a, b, eq, er, ez);
      do_op(sm, a, b, lat);
      chk("rand_latency", 32'(lat), (b == 16'd0) ? 32'd1 : 32'd17);
      chk("rand_quotient", 32'(quotient), 32'(eq));
      chk("rand_remainder", 32'(remainder), 32'(er));
      chk("rand_dbz", 32'(div_by_zero), 32'(ez));
      @(posedge clk); #1;
      chk("rand_done_pulse", 32'(done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
